// File: rtl/key_scan_module.sv
// ---------------------------------------------------------------------------
// key_scan_module
//   Scans a 4x4 active-low keypad matrix one column at a time, debounces
//   whole-keypad frames and reports a single accepted key.
//
// Ports
//   CLK            in   system clock, all logic on the rising edge
//   RSTn           in   asynchronous active-low reset
//   Row_Sense_Sig  in   [3:0] row lines, active-low, asynchronous to CLK
//   Col_Scan_Sig   out  [3:0] column drive, active-low, one-cold
//   Key_Code       out  [3:0] last accepted key code (row*4 + col)
//   Key_Valid      out  one-cycle pulse when a press is accepted
//   Key_Down       out  high while the accepted key is held
// ---------------------------------------------------------------------------
module key_scan_module #(
    parameter int SCAN_CYCLES    = 50000,  // clocks per column slot, >= 4
    parameter int DEBOUNCE_SCANS = 20      // identical frames to accept, 2..255
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] Row_Sense_Sig,
    output logic [3:0] Col_Scan_Sig,
    output logic [3:0] Key_Code,
    output logic       Key_Valid,
    output logic       Key_Down
);

    localparam int                SLOT_W    = $clog2(SCAN_CYCLES);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);
    localparam logic [7:0]        DB_TARGET = 8'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_MULTI} frame_cls_t;

    // -----------------------------------------------------------------------
    // Row synchronizer (idles at 1111 = no key)
    // -----------------------------------------------------------------------
    logic [3:0] row_meta, row_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= Row_Sense_Sig;
            row_sync <= row_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Free-running column scanner
    // -----------------------------------------------------------------------
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic              slot_end, frame_end;

    assign slot_end     = (slot_cnt == SLOT_LAST);
    assign frame_end    = slot_end && (col_idx == 2'd3);
    assign Col_Scan_Sig = ~(4'b0001 << col_idx);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            slot_cnt <= '0;
            col_idx  <= 2'd0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            col_idx  <= col_idx + 2'd1;  // 3 wraps to 0
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Row samples of columns 0..2; column 3 is read live at frame end.
    logic [2:0][3:0] col_samp;

    // NOTE: this small sample store is reset so a frame straddling reset
    // cannot classify stale rows as pressed keys.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            col_samp <= {3{4'hF}};
        end else if (slot_end) begin
            case (col_idx)
                2'd0:    col_samp[0] <= row_sync;
                2'd1:    col_samp[1] <= row_sync;
                2'd2:    col_samp[2] <= row_sync;
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Frame classification
    // -----------------------------------------------------------------------
    logic [3:0][3:0] frame_rows;   // frame_rows[col][row], 0 = pressed
    logic [4:0]      key_cnt;
    logic [3:0]      key_idx;
    frame_cls_t      frame_cls;

    assign frame_rows = {row_sync, col_samp};

    // NOTE: every always_comb output gets a default first so no path can
    // infer a latch.
    always_comb begin
        key_cnt = '0;
        key_idx = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!frame_rows[c][r]) begin
                    key_cnt = key_cnt + 5'd1;
                    key_idx = 4'(r * 4 + c);
                end
            end
        end
        if (key_cnt == 5'd0)      frame_cls = CLS_NONE;
        else if (key_cnt == 5'd1) frame_cls = CLS_ONE;
        else                      frame_cls = CLS_MULTI;
    end

    // -----------------------------------------------------------------------
    // Debounce FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    state_t     state, state_nxt;
    logic [3:0] cand, cand_nxt;
    logic [7:0] count, count_nxt, count_inc;
    logic       same_key, accept, release_done;

    assign count_inc = (count == 8'hFF) ? count : count + 8'd1;  // saturates
    assign same_key  = (frame_cls == CLS_ONE) && (key_idx == cand);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            cand      <= 4'h0;
            count     <= 8'd0;
            Key_Code  <= 4'h0;
            Key_Valid <= 1'b0;
            Key_Down  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            count     <= count_nxt;
            Key_Valid <= accept;
            if (accept) begin
                Key_Code <= cand;
                Key_Down <= 1'b1;
            end else if (release_done) begin
                Key_Down <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (frame_end) begin
            case (state)
                IDLE:     if (frame_cls == CLS_ONE) state_nxt = PRESS_DB;
                PRESS_DB: if (!same_key)               state_nxt = IDLE;
                          else if (count_inc >= DB_TARGET) state_nxt = HELD;
                HELD:     if (frame_cls == CLS_NONE) state_nxt = REL_DB;
                REL_DB:   if (frame_cls != CLS_NONE)   state_nxt = HELD;
                          else if (count_inc >= DB_TARGET) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cand_nxt     = cand;
        count_nxt    = count;
        accept       = 1'b0;
        release_done = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (frame_cls == CLS_ONE) begin
                        cand_nxt  = key_idx;
                        count_nxt = 8'd1;
                    end
                end
                PRESS_DB: begin
                    count_nxt = same_key ? count_inc : 8'd0;
                    accept    = (state_nxt == HELD);
                end
                HELD: begin
                    if (frame_cls == CLS_NONE) count_nxt = 8'd1;
                end
                REL_DB: begin
                    if (frame_cls == CLS_NONE && state_nxt == REL_DB) begin
                        count_nxt = count_inc;
                    end else begin
                        count_nxt    = 8'd0;
                        release_done = (state_nxt == IDLE);
                    end
                end
                default: count_nxt = 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_key_scan_module.sv
module tb_key_scan_module;

    localparam int SC    = 4;
    localparam int DB    = 3;
    localparam int FRAME = 4 * SC;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  code;
    logic        valid;
    logic        down;
    logic [15:0] kp = 16'h0;   // pressed keys, bit index row*4+col

    always #5 clk = ~clk;

    key_scan_module #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
        .CLK           (clk),
        .RSTn          (rst_n),
        .Row_Sense_Sig (row),
        .Col_Scan_Sig  (col),
        .Key_Code      (code),
        .Key_Valid     (valid),
        .Key_Down      (down)
    );

    // Physical keypad: a pressed key shorts its row to a driven-low column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (kp[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle count since reset release; cycle 0 is the one before the first edge.
    int cyc;
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Scoreboard of expected Key_Valid pulses.
    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    // Monitor: column walk and Key_Valid pulses.
    always @(negedge clk) begin : monitor
        logic [1:0] ci;
        logic [3:0] ec;
        exp_t       e;
        if (rst_n) begin
            ci = 2'((cyc / SC) % 4);
            ec = ~(4'b0001 << ci);
            check("col_scan", 32'(col), 32'(ec));
            if (valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got pulse code %0h at cycle %0d expected none", code, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("valid_code", 32'(code), 32'(e.code));
                    check("valid_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Reference model: run-length view of frame history.
    logic       m_down = 1'b0;
    int         m_run  = 0;
    logic [3:0] m_cand = 4'h0;
    logic [3:0] m_last = 4'h0;
    int         frame  = 0;

    task automatic do_frame(input logic [15:0] keys);
        int   n;
        logic [3:0] c;
        exp_t e;
        n = $countones(keys);
        c = 4'h0;
        for (int i = 0; i < 16; i++) if (keys[i]) c = 4'(i);
        if (!m_down) begin
            if (n == 1) begin
                if (m_run > 0 && c == m_cand) m_run++;
                else if (m_run > 0)           m_run = 0;   // new code needs a fresh start
                else begin m_cand = c; m_run = 1; end
            end else begin
                m_run = 0;
            end
            if (m_run == DB) begin
                m_down = 1'b1;
                m_last = m_cand;
                m_run  = 0;
                e.code = m_cand;
                e.cyc  = FRAME * (frame + 1);
                sb_q.push_back(e);
            end
        end else begin
            if (n == 0) m_run++;
            else        m_run = 0;
            if (m_run == DB) begin
                m_down = 1'b0;
                m_run  = 0;
            end
        end
        kp = keys;
        repeat (FRAME) @(posedge clk);
        #1;
        check("key_down", 32'(down), 32'(m_down));
        check("key_code", 32'(code), 32'(m_last));
        frame++;
    endtask

    task automatic frames(input logic [15:0] keys, input int n);
        for (int i = 0; i < n; i++) do_frame(keys);
    endtask

    function automatic logic [15:0] key(input int r, input int c);
        logic [15:0] k;
        k = 16'h0;
        k[r*4+c] = 1'b1;
        return k;
    endfunction

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] ks;
        int          prev;
        int          sel;
        int          a;
        int          b;

        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", 32'(col), 32'h E);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_down", 32'(down), 32'h0);
        check("rst_code", 32'(code), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        frames(16'h0, 3);               // free run, nothing pressed
        frames(key(2, 1), 5);           // accept code 9 after 3rd frame
        frames(16'h0, 2);               // release bounce
        frames(key(2, 1), 1);
        frames(16'h0, 3);               // now released
        frames(key(1, 2), 2);           // too short to accept
        frames(16'h0, 1);
        frames(key(0, 0) | key(1, 1), 3);  // multi from idle
        frames(key(0, 3), 1);
        frames(key(0, 3) | key(3, 3), 1);  // multi during debounce
        frames(key(0, 3), 2);
        frames(key(0, 3), 1);           // third consecutive: accept code 3
        frames(key(1, 0), 1);           // different key while held
        frames(16'h0, 3);
        frames(key(1, 2), 1);           // different code mid-debounce
        frames(key(3, 1), 3);

        // Randomised frames, biased towards repeating the previous key.
        prev = $urandom_range(0, 15);
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                ks = 16'h0;
            end else if (sel < 8) begin
                if ($urandom_range(0, 3) == 0) prev = $urandom_range(0, 15);
                ks = key(prev / 4, prev % 4);
            end else begin
                a  = $urandom_range(0, 15);
                b  = (a + $urandom_range(1, 15)) % 16;
                ks = key(a / 4, a % 4) | key(b / 4, b % 4);
            end
            do_frame(ks);
        end

        // Make Key_Code non-zero, then reset in the middle of a press debounce.
        frames(16'h0, 4);
        frames(key(2, 2), 3);           // accept code 10
        frames(16'h0, 3);
        frames(key(3, 0), 2);           // debouncing code 12
        kp = key(3, 0);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_col", 32'(col), 32'hE);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_down", 32'(down), 32'h0);
        check("midrst_code", 32'(code), 32'h0);
        check("midrst_sb_empty", 32'(sb_q.size()), 32'h0);
        m_down = 1'b0;
        m_run  = 0;
        m_last = 4'h0;
        frame  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        frames(key(3, 0), 2);           // earlier progress discarded
        frames(key(3, 0), 1);           // accept code 12 now
        frames(16'h0, 3);
        repeat (4) @(posedge clk);
        #1;
        check("final_sb_empty", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_scan_module.md
KEY_SCAN_MODULE -- requirements
Module: key_scan_module

Interface
REQ-001 SHALL provide parameter SCAN_CYCLES, default 50000, meaning CLK cycles per column slot (1 ms at 50 MHz); legal range 4 or more.
REQ-002 SHALL provide parameter DEBOUNCE_SCANS, default 20, meaning consecutive identical full-scan frames required to accept a press or a release; legal range 2 to 255.
REQ-003 SHALL provide port CLK, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-004 SHALL provide port RSTn, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL provide port Row_Sense_Sig, input, 4 bits, keypad row lines, active-low (pulled up), asynchronous to CLK.
REQ-006 SHALL provide port Col_Scan_Sig, output, 4 bits, keypad column drive, active-low, one-cold.
REQ-007 SHALL provide port Key_Code, output, 4 bits, accepted key code.
REQ-008 SHALL provide port Key_Valid, output, 1 bit, one-cycle pulse on press acceptance.
REQ-009 SHALL provide port Key_Down, output, 1 bit, level, high while an accepted key is held.

Function
REQ-010 SHALL pass Row_Sense_Sig through a 2-flop synchronizer before any use.
REQ-011 SHALL drive exactly one Col_Scan_Sig bit low at all times: column 0 (4'b1110), then 1, 2, 3, wrapping from 3 back to 0, each for SCAN_CYCLES cycles.
REQ-012 SHALL sample the synchronized rows on the last cycle of each column slot; any row bit read as 0 marks key (row, col) pressed.
REQ-013 SHALL form a frame from the four slot samples of columns 0 to 3; frame end is the last cycle of the column-3 slot.
REQ-014 SHALL classify each frame as NONE (0 keys), ONE (exactly 1 key, code = row*4 + col), or MULTI (2 or more keys).
REQ-015 SHALL implement FSM states IDLE, PRESS_DB, HELD and REL_DB, evaluated only at frame end.
REQ-016 In IDLE: ONE(c) SHALL latch candidate c, set the count to 1 and go to PRESS_DB; NONE or MULTI SHALL stay in IDLE.
REQ-017 In PRESS_DB: ONE(same c) SHALL increment the count; NONE, MULTI or ONE(different code) SHALL clear the count and return to IDLE.
REQ-018 When the PRESS_DB count reaches DEBOUNCE_SCANS, the FSM SHALL go to HELD and, on the next cycle, set Key_Code = c, set Key_Down = 1 and pulse Key_Valid high for exactly one cycle.
REQ-019 In HELD: NONE SHALL set the count to 1 and go to REL_DB; ONE or MULTI (any code) SHALL stay in HELD, with no new Key_Valid.
REQ-020 In REL_DB: NONE SHALL increment the count; any pressed key SHALL return to HELD.
REQ-021 When the REL_DB count reaches DEBOUNCE_SCANS, the FSM SHALL clear Key_Down on the next cycle and go to IDLE.
REQ-022 Key_Code SHALL hold its last accepted value until the next acceptance.
REQ-023 Column scanning SHALL never stall, regardless of FSM state.
REQ-024 The debounce count SHALL be 8 bits and SHALL saturate, never wrap.

Reset
REQ-025 While RSTn = 0, and immediately on its assertion (asynchronous, including mid-frame or mid-debounce), the block SHALL force: FSM = IDLE; slot counter, column index and count = 0; Col_Scan_Sig = 4'b1110; Key_Code = 4'h0; Key_Valid = 0; Key_Down = 0; synchronizer flops = 4'b1111.
REQ-026 After RSTn deasserts, scanning SHALL restart at column 0, cycle 0.
REQ-027 Any partial debounce in progress at reset SHALL be discarded.

Verification (SCAN_CYCLES=4, DEBOUNCE_SCANS=3)
REQ-028 Free run, rows all 1: Col_Scan_Sig steps 1110, 1101, 1011, 0111 every 4 cycles and wraps; Key_Valid and Key_Down stay 0.
REQ-029 Key (row 2, col 1) held for 5 frames: exactly one Key_Valid pulse, 1 cycle after the 3rd frame end; Key_Code = 4'h9; Key_Down = 1.
REQ-030 Press for 2 frames then release: no Key_Valid pulse; Key_Code unchanged.
REQ-031 Accepted key released for 2 frames, pressed again, then released for 3 frames: Key_Down stays 1 until 1 cycle after the 3rd consecutive NONE frame end, then 0; no second Key_Valid pulse.
REQ-032 Two keys in one frame from IDLE: no acceptance; a MULTI frame during PRESS_DB returns the FSM to IDLE.
REQ-033 RSTn pulsed low mid-PRESS_DB: outputs go to reset values immediately; after release, a full 3 frames are required for acceptance.
